// File: rtl/conflict_scan.sv
// Sequential piece/field collision checker: tests one mask cell per clock against the captured field.
// Latency 1+BLK*BLK cycles (or 2+k on early exit at cell k); start is ignored while busy and is never queued.
module conflict_scan #(
  parameter int FIELD_W    = 10,
  parameter int FIELD_H    = 10,
  parameter int BLK        = 3,
  parameter int POS_W      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [0:FIELD_W*FIELD_H-1]   field,
  input  logic [0:BLK*BLK-1]           block,
  input  logic [POS_W-1:0]             blockX,
  input  logic [POS_W-1:0]             blockY,
  output logic                         busy,
  output logic                         done,
  output logic                         conflict,
  output logic                         oob
);

  localparam int NCELL = BLK * BLK;
  localparam int NF    = FIELD_W * FIELD_H;
  localparam int KW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int XW    = (BLK > 1) ? $clog2(BLK) : 1;
  localparam int IW    = (NF > 1) ? $clog2(NF) : 1;
  localparam int CW    = POS_W + 1;

  localparam logic [KW-1:0] K_LAST = KW'(NCELL - 1);
  localparam logic [XW-1:0] X_LAST = XW'(BLK - 1);
  localparam logic [CW-1:0] W_LIM  = CW'(FIELD_W);
  localparam logic [CW-1:0] H_LIM  = CW'(FIELD_H);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [0:NF-1]       r_field;
  logic [0:NCELL-1]    r_block;
  logic [POS_W-1:0]    r_bx;
  logic [POS_W-1:0]    r_by;
  logic [KW-1:0]       r_k;
  logic [XW-1:0]       r_x;
  logic [XW-1:0]       r_y;
  logic                r_conflict;
  logic                r_oob;
  logic                r_done;

  logic [CW-1:0]       w_col;
  logic [CW-1:0]       w_row;
  logic                w_solid;
  logic                w_cell_oob;
  logic                w_in_bounds;
  logic [IW-1:0]       w_idx;
  logic                w_hit;
  logic                w_cell_conf;
  logic                w_last;
  logic                w_accept;
  logic                w_finish;

  // One extra bit on col/row so a mask hanging past the last position never wraps back in.
  assign w_col       = {1'b0, r_bx} + CW'(r_x);
  assign w_row       = {1'b0, r_by} + CW'(r_y);
  assign w_solid     = r_block[r_k];
  assign w_cell_oob  = w_solid && ((w_col >= W_LIM) || (w_row >= H_LIM));
  assign w_in_bounds = w_solid && (w_col < W_LIM) && (w_row < H_LIM);
  assign w_idx       = w_in_bounds ? (IW'(w_row) * IW'(FIELD_W) + IW'(w_col)) : '0;
  assign w_hit       = w_in_bounds && r_field[w_idx];
  assign w_cell_conf = w_cell_oob || w_hit;
  assign w_last      = (r_k == K_LAST);
  assign w_accept    = start && (r_state == S_IDLE);
  assign w_finish    = (r_state == S_SCAN) && (w_last || ((EARLY_EXIT != 0) && w_cell_conf));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SCAN;
      S_SCAN:  if (w_finish) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_field    <= '0;
      r_block    <= '0;
      r_bx       <= '0;
      r_by       <= '0;
      r_k        <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_conflict <= 1'b0;
      r_oob      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_field    <= field;
        r_block    <= block;
        r_bx       <= blockX;
        r_by       <= blockY;
        r_k        <= '0;
        r_x        <= '0;
        r_y        <= '0;
        r_conflict <= 1'b0;
        r_oob      <= 1'b0;
      end else if (r_state == S_SCAN) begin
        if (w_cell_conf) r_conflict <= 1'b1;
        if (w_cell_oob)  r_oob      <= 1'b1;
        // x/y walk alongside k so no divider is needed for the mask coordinates.
        if (!w_last) begin
          r_k <= r_k + KW'(1);
          if (r_x == X_LAST) begin
            r_x <= '0;
            r_y <= r_y + XW'(1);
          end else begin
            r_x <= r_x + XW'(1);
          end
        end
      end
    end
  end

  assign busy     = (r_state == S_SCAN);
  assign done     = r_done;
  assign conflict = r_conflict;
  assign oob      = r_oob;

endmodule

// File: tb/tb_conflict_scan.sv
// Bench for conflict_scan: early-exit and full-scan 10x10/3x3 instances share stimulus, plus a 12x20/4x4 instance.
module tb_conflict_scan;

  logic        clk;
  logic        rst_n;
  logic        start_a, start_b, start_c;
  logic [0:99] fld;
  logic [8:0]  blk;
  logic [3:0]  bx, by;
  logic        busy_a, done_a, conflict_a, oob_a;
  logic        busy_b, done_b, conflict_b, oob_b;
  logic [0:239] fld_c;
  logic [15:0] blk_c;
  logic [4:0]  bxc, byc;
  logic        busy_c, done_c, conflict_c, oob_c;

  int n_pass, n_total;

  conflict_scan #(.EARLY_EXIT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .field(fld), .block(blk),
    .blockX(bx), .blockY(by), .busy(busy_a), .done(done_a), .conflict(conflict_a), .oob(oob_a));

  conflict_scan #(.EARLY_EXIT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .field(fld), .block(blk),
    .blockX(bx), .blockY(by), .busy(busy_b), .done(done_b), .conflict(conflict_b), .oob(oob_b));

  conflict_scan #(.FIELD_W(12), .FIELD_H(20), .BLK(4), .POS_W(5), .EARLY_EXIT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .field(fld_c), .block(blk_c),
    .blockX(bxc), .blockY(byc), .busy(busy_c), .done(done_c), .conflict(conflict_c), .oob(oob_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         fidx;
    logic [8:0] blk;
    int         x;
    int         y;
    int         la;
    int         lb;
    logic       ca;
    logic       oa;
    logic       cb;
    logic       ob;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Starts A and B together; latency counts cycles after the accepting edge.
  task automatic run_ab(input int fidx, input logic [8:0] b, input int x, input int y,
                        output int la, output int lb, output logic ca, output logic oa,
                        output logic cb, output logic ob, output int berr);
    fld = '0;
    if (fidx >= 0) fld[fidx] = 1'b1;
    blk = b; bx = 4'(x); by = 4'(y);
    la = -1; lb = -1; ca = 1'b0; oa = 1'b0; cb = 1'b0; ob = 1'b0; berr = 0;
    start_a = 1'b1; start_b = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0; start_b = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (la < 0) begin
        if (done_a) begin la = c; ca = conflict_a; oa = oob_a; if (busy_a) berr++; end
        else if (!busy_a) berr++;
      end else if (done_a || busy_a) berr++;
      if (lb < 0) begin
        if (done_b) begin lb = c; cb = conflict_b; ob = oob_b; if (busy_b) berr++; end
        else if (!busy_b) berr++;
      end else if (done_b || busy_b) berr++;
    end
  endtask

  task automatic run_c(input int fidx, input int x, input int y,
                       output int lat, output logic c, output logic o);
    fld_c = '0;
    if (fidx >= 0) fld_c[fidx] = 1'b1;
    blk_c = 16'h0001;
    bxc = 5'(x); byc = 5'(y);
    lat = -1; c = 1'b0; o = 1'b0;
    start_c = 1'b1;
    @(posedge clk);
    #1 start_c = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done_c && lat < 0) begin lat = k; c = conflict_c; o = oob_c; end
    end
  endtask

  int   la, lb, berr, first_done, ndone;
  logic ca, oa, cb, ob;

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    fld = '0; blk = '0; bx = '0; by = '0;
    fld_c = '0; blk_c = '0; bxc = '0; byc = '0;

    vecs[0] = '{"empty_T",     -1, 9'b010111000,  3,  4, 10, 10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"hit54",       54, 9'b010111000,  3,  4,  6, 10, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{"wall_x8",     -1, 9'b001001001,  8,  0,  4, 10, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{"edge_x7",     -1, 9'b001001001,  7,  0, 10, 10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{"floor_y8",    -1, 9'b000000100,  0,  8,  8, 10, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{"empty_mask",  -1, 9'b000000000, 15, 15, 10, 10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{"hit_cell0",    0, 9'b100000000,  0,  0,  2, 10, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{"partial_oob",  9, 9'b100000001,  9,  0,  2, 10, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{"no_wrap",      0, 9'b001000000, 14,  0,  4, 10, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{"corner_99",   99, 9'b000000001,  7,  7, 10, 10, 1'b1, 1'b0, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_busy_a", busy_a, 0);         chk("rst_done_a", done_a, 0);
    chk("rst_conflict_a", conflict_a, 0); chk("rst_oob_a", oob_a, 0);
    chk("rst_busy_b", busy_b, 0);         chk("rst_done_b", done_b, 0);
    chk("rst_conflict_b", conflict_b, 0); chk("rst_oob_b", oob_b, 0);
    chk("rst_busy_c", busy_c, 0);         chk("rst_done_c", done_c, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_ab(vecs[i].fidx, vecs[i].blk, vecs[i].x, vecs[i].y, la, lb, ca, oa, cb, ob, berr);
      chk({vecs[i].name, "/latA"}, la, vecs[i].la);
      chk({vecs[i].name, "/latB"}, lb, vecs[i].lb);
      chk({vecs[i].name, "/confA"}, ca, vecs[i].ca);
      chk({vecs[i].name, "/oobA"}, oa, vecs[i].oa);
      chk({vecs[i].name, "/confB"}, cb, vecs[i].cb);
      chk({vecs[i].name, "/oobB"}, ob, vecs[i].ob);
      chk({vecs[i].name, "/busy_done_shape"}, berr, 0);
    end

    // Start pulse mid-scan is dropped; start in the done cycle launches a fresh scan.
    fld = '0; fld[54] = 1'b1; blk = 9'b010111000; bx = 4'd3; by = 4'd4;
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    first_done = -1; ndone = 0; cb = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done_b) begin
        ndone++;
        if (first_done < 0) begin first_done = c; cb = conflict_b; end
      end
      start_b = (c == 3 || c == 10);
      if (c == 10) fld = '0;
    end
    chk("ignore_start/done_cycle", first_done, 10);
    chk("ignore_start/done_count", ndone, 1);
    chk("ignore_start/conflict", cb, 1);
    @(negedge clk);
    chk("restart/busy_n11", busy_b, 1);
    chk("restart/conflict_cleared", conflict_b, 0);
    chk("restart/done_low", done_b, 0);
    start_b = 1'b0;
    first_done = -1; cb = 1'b1;
    for (int c = 12; c <= 22; c++) begin
      @(negedge clk);
      if (done_b && first_done < 0) begin first_done = c; cb = conflict_b; end
    end
    chk("restart/done_cycle", first_done, 20);
    chk("restart/conflict", cb, 0);

    // Reset in the middle of a scan that has already flagged a conflict.
    fld = '0; fld[0] = 1'b1; blk = 9'b100000000; bx = 4'd0; by = 4'd0;
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst/pre_busy", busy_b, 1);
    chk("midrst/pre_conflict", conflict_b, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst/busy", busy_b, 0);
    chk("midrst/done", done_b, 0);
    chk("midrst/conflict", conflict_b, 0);
    chk("midrst/oob", oob_b, 0);
    ndone = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 3) rst_n = 1'b1;
      if (done_b) ndone++;
    end
    chk("midrst/no_done", ndone, 0);
    chk("midrst/idle_after", busy_b, 0);

    run_ab(vecs[1].fidx, vecs[1].blk, vecs[1].x, vecs[1].y, la, lb, ca, oa, cb, ob, berr);
    chk("postrst/latA", la, 6);
    chk("postrst/latB", lb, 10);
    chk("postrst/confA", ca, 1);
    chk("postrst/confB", cb, 1);
    chk("postrst/oobA", oa, 0);
    chk("postrst/shape", berr, 0);
    repeat (3) @(negedge clk);
    chk("hold/conflict_a", conflict_a, 1);
    chk("hold/conflict_b", conflict_b, 1);
    chk("hold/oob_b", oob_b, 0);

    // Larger geometry: mask cell 15 lands on row 19 / col 11.
    run_c(239, 8, 16, la, ca, oa);
    chk("big/hit239_lat", la, 17);
    chk("big/hit239_conf", ca, 1);
    chk("big/hit239_oob", oa, 0);
    run_c(-1, 8, 16, la, ca, oa);
    chk("big/empty_lat", la, 17);
    chk("big/empty_conf", ca, 0);
    chk("big/empty_oob", oa, 0);
    run_c(-1, 9, 16, la, ca, oa);
    chk("big/col12_lat", la, 17);
    chk("big/col12_conf", ca, 1);
    chk("big/col12_oob", oa, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
